// File: rtl/lcd_pkg.sv
// lcd_pkg: shared constants, types and address helpers for the character-LCD responder.
package lcd_pkg;

    // Bit positions inside the 5-bit writer control bus
    localparam int unsigned CTL_RW   = 0;
    localparam int unsigned CTL_RS   = 1;
    localparam int unsigned CTL_ON   = 2;
    localparam int unsigned CTL_EN   = 3;
    localparam int unsigned CTL_BLON = 4;

    // Instruction opcode masks; the highest set bit selects the instruction
    localparam logic [7:0] CMD_SET_DDRAM = 8'h80;
    localparam logic [7:0] CMD_SET_CGRAM = 8'h40;
    localparam logic [7:0] CMD_FUNC_SET  = 8'h20;
    localparam logic [7:0] CMD_SHIFT     = 8'h10;
    localparam logic [7:0] CMD_DISP_CTL  = 8'h08;
    localparam logic [7:0] CMD_ENTRY     = 8'h04;
    localparam logic [7:0] CMD_HOME      = 8'h02;
    localparam logic [7:0] CMD_CLEAR     = 8'h01;

    localparam int unsigned LINE_LEN   = 40;
    localparam logic [6:0]  LINE2_BASE = 7'h40;
    localparam int unsigned DDRAM_SIZE = 80;
    localparam logic [7:0]  SPACE      = 8'h20;

    typedef enum logic [1:0] {StIdle, StExec, StBusy, StFill} state_e;

    typedef enum logic [3:0] {
        OpNop, OpClear, OpHome, OpEntry, OpDispCtl, OpShift, OpFuncSet, OpSetCgram, OpSetDdram
    } op_e;

    function automatic op_e decode_cmd(input logic [7:0] d);
        if ((d & CMD_SET_DDRAM) != 8'h00)     return OpSetDdram;
        else if ((d & CMD_SET_CGRAM) != 8'h00) return OpSetCgram;
        else if ((d & CMD_FUNC_SET) != 8'h00)  return OpFuncSet;
        else if ((d & CMD_SHIFT) != 8'h00)     return OpShift;
        else if ((d & CMD_DISP_CTL) != 8'h00)  return OpDispCtl;
        else if ((d & CMD_ENTRY) != 8'h00)     return OpEntry;
        else if ((d & CMD_HOME) != 8'h00)      return OpHome;
        else if ((d & CMD_CLEAR) != 8'h00)     return OpClear;
        return OpNop;
    endfunction

    // DDRAM address maps to a stored byte only on 0x00-0x27 and 0x40-0x67
    function automatic logic ddram_valid(input logic [6:0] a);
        return (a < 7'(LINE_LEN)) || (a >= LINE2_BASE && a < LINE2_BASE + 7'(LINE_LEN));
    endfunction

    function automatic logic [6:0] ddram_index(input logic [6:0] a);
        return (a < 7'(LINE_LEN)) ? a : a - (LINE2_BASE - 7'(LINE_LEN));
    endfunction

    // Address counter step in DDRAM mode, wrapping line 1 <-> line 2
    function automatic logic [6:0] ddram_step(input logic [6:0] a, input logic inc);
        logic [6:0] r;
        if (inc) begin
            if (a >= 7'(LINE_LEN - 1) && a < LINE2_BASE)     r = LINE2_BASE;
            else if (a >= LINE2_BASE + 7'(LINE_LEN - 1))     r = 7'h00;
            else                                             r = a + 7'd1;
        end else begin
            if (a == 7'h00)            r = LINE2_BASE + 7'(LINE_LEN - 1);
            else if (a == LINE2_BASE)  r = 7'(LINE_LEN - 1);
            else                       r = a - 7'd1;
        end
        return r;
    endfunction

    function automatic logic [6:0] cgram_step(input logic [6:0] a, input logic inc);
        return {1'b0, inc ? a[5:0] + 6'd1 : a[5:0] - 6'd1};
    endfunction

endpackage

// File: rtl/lcd_responder_if.sv
// lcd_responder_if: writer-to-display bus (control, data and busy flag).
interface lcd_responder_if;
    logic [4:0] ctl;
    logic [7:0] data;
    logic       busy;

    modport master (output ctl, output data, input busy);
    modport slave  (input ctl, input data, output busy);
endinterface

// File: rtl/lcd_ddram.sv
// lcd_ddram: 80x8 display RAM, one synchronous write port and one registered read port.
module lcd_ddram
    import lcd_pkg::*;
(
    input  logic       clk,
    input  logic       we,
    input  logic [6:0] waddr,
    input  logic [7:0] wdata,
    input  logic [6:0] raddr,
    output logic [7:0] rdata
);
    logic [7:0] mem [DDRAM_SIZE];

    // Write first in source order but read returns the pre-write value on a collision
    always_ff @(posedge clk) begin
        if (we && waddr < 7'(DDRAM_SIZE)) begin
            mem[waddr] <= wdata;
        end
        if (raddr < 7'(DDRAM_SIZE)) begin
            rdata <= mem[raddr];
        end else begin
            rdata <= 8'h00;
        end
    end
endmodule

// File: rtl/lcd_responder.sv
// lcd_responder: HD44780-style display model. Decodes writes from the LCD writer bus on the EN
// falling edge, models the busy period, and mirrors the 2x40 DDRAM through a read port.
module lcd_responder
    import lcd_pkg::*;
#(
    parameter int unsigned BUSY_CYCLES  = 2000,
    parameter int unsigned CLEAR_CYCLES = 82000
) (
    input  logic           clk,
    input  logic           rst_n,
    lcd_responder_if.slave bus,
    input  logic [6:0]     rd_addr,
    output logic [7:0]     rd_data,
    output logic [6:0]     ac,
    output logic           disp_on,
    output logic           cursor_on,
    output logic           blink_on,
    output logic           incr,
    output logic           two_line,
    output logic           wr_strobe,
    output logic           overrun,
    output logic           addr_err
);
    localparam int unsigned FillCycles = DDRAM_SIZE + 2;
    localparam int unsigned MaxCmd     = (BUSY_CYCLES > CLEAR_CYCLES) ? BUSY_CYCLES : CLEAR_CYCLES;
    localparam int unsigned MaxCycles  = (MaxCmd > FillCycles) ? MaxCmd : FillCycles;
    localparam int unsigned CntW       = $clog2(MaxCycles + 1);
    localparam logic [CntW-1:0] BusyLast  = CntW'(BUSY_CYCLES - 1);
    localparam logic [CntW-1:0] ClearLast = CntW'(CLEAR_CYCLES - 1);

    state_e          state_q;
    logic [CntW-1:0] cnt_q;
    logic [6:0]      fill_idx_q;
    logic            boot_q;     // current fill is the power-up fill (no trailing busy time)
    logic            long_q;     // current command is clear-display
    logic            en_q;
    logic            rs_q;
    logic [7:0]      data_q;
    logic            cgram_q;
    logic [6:0]      ac_q;
    logic            disp_q, cursor_q, blink_q, incr_q, two_line_q;
    logic            busy_q, wr_strobe_q, overrun_q, addr_err_q;

    logic            strobe;
    logic            ram_we;
    logic [6:0]      ram_waddr;
    logic [7:0]      ram_wdata;
    logic            unused_blon;

    assign strobe = en_q & ~bus.ctl[CTL_EN] & bus.ctl[CTL_ON] & ~bus.ctl[CTL_RW];
    assign unused_blon = bus.ctl[CTL_BLON];

    // RAM write source: space fill, or the data byte being executed
    always_comb begin
        ram_we    = 1'b0;
        ram_waddr = fill_idx_q;
        ram_wdata = SPACE;
        if (rst_n) begin
            if (state_q == StFill) begin
                ram_we = 1'b1;
            end else if (state_q == StExec && rs_q && !cgram_q && ddram_valid(ac_q)) begin
                ram_we    = 1'b1;
                ram_waddr = ddram_index(ac_q);
                ram_wdata = data_q;
            end
        end
    end

    // Control FSM: accept, execute, fill and busy timing with registered status outputs
    always_ff @(posedge clk) begin
        wr_strobe_q <= 1'b0;
        overrun_q   <= 1'b0;
        addr_err_q  <= 1'b0;
        if (!rst_n) begin
            state_q    <= StFill;
            cnt_q      <= '0;
            fill_idx_q <= 7'd0;
            boot_q     <= 1'b1;
            long_q     <= 1'b0;
            en_q       <= 1'b0;
            rs_q       <= 1'b0;
            data_q     <= 8'h00;
            cgram_q    <= 1'b0;
            ac_q       <= 7'h00;
            disp_q     <= 1'b0;
            cursor_q   <= 1'b0;
            blink_q    <= 1'b0;
            incr_q     <= 1'b1;
            two_line_q <= 1'b0;
            busy_q     <= 1'b1;
        end else begin
            en_q <= bus.ctl[CTL_EN];
            if (strobe && state_q != StIdle) begin
                overrun_q <= 1'b1;
            end
            unique case (state_q)
                StIdle: begin
                    if (strobe) begin
                        state_q     <= StExec;
                        busy_q      <= 1'b1;
                        cnt_q       <= '0;
                        long_q      <= 1'b0;
                        rs_q        <= bus.ctl[CTL_RS];
                        data_q      <= bus.data;
                        wr_strobe_q <= 1'b1;
                    end
                end
                StExec: begin
                    cnt_q   <= cnt_q + CntW'(1);
                    state_q <= StBusy;
                    if (rs_q) begin
                        if (cgram_q) begin
                            ac_q <= cgram_step(ac_q, incr_q);
                        end else begin
                            addr_err_q <= ~ddram_valid(ac_q);
                            ac_q       <= ddram_step(ac_q, incr_q);
                        end
                    end else begin
                        unique case (decode_cmd(data_q))
                            OpSetDdram: begin
                                ac_q    <= data_q[6:0];
                                cgram_q <= 1'b0;
                            end
                            OpSetCgram: begin
                                ac_q    <= {1'b0, data_q[5:0]};
                                cgram_q <= 1'b1;
                            end
                            OpFuncSet: two_line_q <= data_q[3];
                            OpShift: begin
                                // Display shift (S/C=1) has no effect on the mirror
                                if (!data_q[3]) begin
                                    ac_q <= cgram_q ? cgram_step(ac_q, data_q[2])
                                                    : ddram_step(ac_q, data_q[2]);
                                end
                            end
                            OpDispCtl: {disp_q, cursor_q, blink_q} <= data_q[2:0];
                            OpEntry:   incr_q <= data_q[1];
                            OpHome: begin
                                ac_q    <= 7'h00;
                                cgram_q <= 1'b0;
                            end
                            OpClear: begin
                                ac_q       <= 7'h00;
                                incr_q     <= 1'b1;
                                cgram_q    <= 1'b0;
                                long_q     <= 1'b1;
                                fill_idx_q <= 7'd0;
                                state_q    <= StFill;
                            end
                            OpNop: ;
                            default: ;
                        endcase
                    end
                end
                StFill: begin
                    cnt_q      <= cnt_q + CntW'(1);
                    fill_idx_q <= fill_idx_q + 7'd1;
                    if (fill_idx_q == 7'(DDRAM_SIZE - 1)) begin
                        if (boot_q) begin
                            state_q <= StIdle;
                            busy_q  <= 1'b0;
                            boot_q  <= 1'b0;
                        end else begin
                            state_q <= StBusy;
                        end
                    end
                end
                StBusy: begin
                    cnt_q <= cnt_q + CntW'(1);
                    if (cnt_q >= (long_q ? ClearLast : BusyLast)) begin
                        state_q <= StIdle;
                        busy_q  <= 1'b0;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    lcd_ddram u_ddram (
        .clk   (clk),
        .we    (ram_we),
        .waddr (ram_waddr),
        .wdata (ram_wdata),
        .raddr (rd_addr),
        .rdata (rd_data)
    );

    assign bus.busy  = busy_q;
    assign ac        = ac_q;
    assign disp_on   = disp_q;
    assign cursor_on = cursor_q;
    assign blink_on  = blink_q;
    assign incr      = incr_q;
    assign two_line  = two_line_q;
    assign wr_strobe = wr_strobe_q;
    assign overrun   = overrun_q;
    assign addr_err  = addr_err_q;
endmodule

// File: tb/tb_lcd_responder.sv
// tb_lcd_responder: table-driven and randomized checks of lcd_responder against a position-based
// model of the display (linear index 0..79, wrap by modular arithmetic).
module tb_lcd_responder;
    localparam int unsigned BusyCyc  = 40;
    localparam int unsigned ClearCyc = 200;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [6:0] rd_addr;
    logic [7:0] rd_data;
    logic [6:0] ac;
    logic       disp_on, cursor_on, blink_on, incr, two_line, wr_strobe, overrun, addr_err;

    lcd_responder_if bus ();

    lcd_responder #(.BUSY_CYCLES(BusyCyc), .CLEAR_CYCLES(ClearCyc)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .bus       (bus),
        .rd_addr   (rd_addr),
        .rd_data   (rd_data),
        .ac        (ac),
        .disp_on   (disp_on),
        .cursor_on (cursor_on),
        .blink_on  (blink_on),
        .incr      (incr),
        .two_line  (two_line),
        .wr_strobe (wr_strobe),
        .overrun   (overrun),
        .addr_err  (addr_err)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic       rs;
        logic [7:0] d;
        logic [6:0] ac;
        logic [4:0] fl;   // {disp, cursor, blink, incr, two_line}
        logic       err;
    } vec_t;

    vec_t vecs[$];
    int   n_vec = 0;
    int   n_bad = 0;

    // Reference model state
    int   m_ac;
    bit   m_cg, m_incr, m_disp, m_cur, m_blink, m_two;
    logic [7:0] m_mem [80];

    function automatic void add(input bit rs, input logic [7:0] d, input logic [6:0] a,
                                input logic [4:0] fl, input bit err);
        vec_t v;
        v = {rs, d, a, fl, err};
        vecs.push_back(v);
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // One writer transaction: EN high for a cycle, then low; returns one cycle after the strobe
    task automatic wr(input bit rs, input logic [7:0] d, input bit on = 1'b1, input bit rw = 1'b0);
        bus.data = d;
        bus.ctl  = {1'($urandom_range(0, 1)), 1'b1, on, rs, rw};
        tick();
        bus.ctl[3] = 1'b0;
        tick();
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 400 && bus.busy; i++) tick();
        chk("busy_timeout", 32'(bus.busy), 32'd0);
    endtask

    task automatic rd(input int idx, output logic [7:0] v);
        rd_addr = 7'(idx);
        tick();
        v = rd_data;
    endtask

    function automatic int lin(input int a);
        if (a < 40) return a;
        if (a >= 64 && a < 104) return a - 24;
        return -1;
    endfunction

    function automatic int step(input int a, input bit inc, input bit cg);
        int p;
        if (cg) return inc ? (a + 1) % 64 : (a + 63) % 64;
        p = lin(a);
        if (p >= 0) begin
            p = (p + (inc ? 1 : 79)) % 80;
            return (p < 40) ? p : p + 24;
        end
        if (inc) return (a < 64) ? 64 : 0;
        return (a + 127) % 128;
    endfunction

    function automatic void model_reset();
        m_ac = 0; m_cg = 0; m_incr = 1; m_disp = 0; m_cur = 0; m_blink = 0; m_two = 0;
        for (int i = 0; i < 80; i++) m_mem[i] = 8'h20;
    endfunction

    // Applies one accepted write to the model; returns the expected addr_err pulse
    function automatic bit model_write(input bit rs, input logic [7:0] d);
        int p;
        if (rs) begin
            if (m_cg) begin
                m_ac = step(m_ac, m_incr, 1'b1);
            end else begin
                p = lin(m_ac);
                m_ac = step(m_ac, m_incr, 1'b0);
                if (p < 0) return 1'b1;
                m_mem[p] = d;
            end
        end else if (d[7]) begin
            m_ac = int'(d[6:0]); m_cg = 0;
        end else if (d[6]) begin
            m_ac = int'(d[5:0]); m_cg = 1;
        end else if (d[5]) begin
            m_two = d[3];
        end else if (d[4]) begin
            if (!d[3]) m_ac = step(m_ac, d[2], m_cg);
        end else if (d[3]) begin
            {m_disp, m_cur, m_blink} = d[2:0];
        end else if (d[2]) begin
            m_incr = d[1];
        end else if (d[1]) begin
            m_ac = 0; m_cg = 0;
        end else if (d[0]) begin
            m_ac = 0; m_cg = 0; m_incr = 1;
            for (int i = 0; i < 80; i++) m_mem[i] = 8'h20;
        end
        return 1'b0;
    endfunction

    task automatic cmp_ram(input string name);
        logic [7:0] v;
        for (int i = 0; i < 80; i++) begin
            rd(i, v);
            chk(name, 32'(v), 32'(m_mem[i]));
        end
    endtask

    task automatic fill_check(input string name);
        tick(79);
        chk({name, "_busy79"}, 32'(bus.busy), 32'd1);
        tick();
        chk({name, "_busy80"}, 32'(bus.busy), 32'd0);
    endtask

    logic [7:0] v;
    bit         rs, e;
    logic [7:0] d;
    int         sav_ac;

    initial begin
        bus.ctl  = 5'b0;
        bus.data = 8'h00;
        rd_addr  = 7'd0;
        rst_n    = 1'b0;

        add(0, 8'h38, 7'h00, 5'b00011, 0);
        add(0, 8'h0C, 7'h00, 5'b10011, 0);
        add(0, 8'h01, 7'h00, 5'b10011, 0);
        add(0, 8'h06, 7'h00, 5'b10011, 0);
        add(0, 8'h80, 7'h00, 5'b10011, 0);
        for (int i = 0; i < 16; i++) add(1, 8'h41 + 8'(i), 7'(i + 1), 5'b10011, 0);
        add(0, 8'hA7, 7'h27, 5'b10011, 0);
        add(1, 8'h58, 7'h40, 5'b10011, 0);
        add(1, 8'h59, 7'h41, 5'b10011, 0);
        add(0, 8'h04, 7'h41, 5'b10001, 0);
        add(0, 8'h80, 7'h00, 5'b10001, 0);
        add(1, 8'h5A, 7'h67, 5'b10001, 0);
        add(0, 8'h06, 7'h67, 5'b10011, 0);
        add(0, 8'hA8, 7'h28, 5'b10011, 0);
        add(1, 8'h41, 7'h40, 5'b10011, 1);
        add(0, 8'h0F, 7'h40, 5'b11111, 0);
        add(0, 8'h14, 7'h41, 5'b11111, 0);
        add(0, 8'h10, 7'h40, 5'b11111, 0);
        add(0, 8'h18, 7'h40, 5'b11111, 0);
        add(0, 8'h40, 7'h00, 5'b11111, 0);
        for (int i = 0; i < 3; i++) add(1, 8'h11, 7'(i + 1), 5'b11111, 0);
        add(0, 8'h02, 7'h00, 5'b11111, 0);
        add(0, 8'h00, 7'h00, 5'b11111, 0);
        add(0, 8'h20, 7'h00, 5'b11110, 0);

        // Reset state and power-up fill timing
        tick(2);
        chk("rst_busy", 32'(bus.busy), 32'd1);
        chk("rst_ac", 32'(ac), 32'd0);
        chk("rst_flags", 32'({disp_on, cursor_on, blink_on, incr, two_line}), 32'b00010);
        chk("rst_pulses", 32'({wr_strobe, overrun, addr_err}), 32'd0);
        rst_n = 1'b1;
        model_reset();
        fill_check("boot");
        cmp_ram("boot_ram");

        // Table-driven writer sequence
        foreach (vecs[i]) begin
            wr(vecs[i].rs, vecs[i].d);
            chk("tbl_strobe", 32'(wr_strobe), 32'd1);
            tick();
            chk("tbl_addr_err", 32'(addr_err), 32'(vecs[i].err));
            e = model_write(vecs[i].rs, vecs[i].d);
            wait_idle();
            chk("tbl_ac", 32'(ac), 32'(vecs[i].ac));
            chk("tbl_flags", 32'({disp_on, cursor_on, blink_on, incr, two_line}),
                32'(vecs[i].fl));
        end
        rd(0, v);  chk("ram0", 32'(v), 32'h5A);
        rd(15, v); chk("ram15", 32'(v), 32'h50);
        rd(16, v); chk("ram16", 32'(v), 32'h20);
        rd(39, v); chk("ram39", 32'(v), 32'h58);
        rd(40, v); chk("ram40", 32'(v), 32'h59);
        rd(41, v); chk("ram41", 32'(v), 32'h20);
        cmp_ram("tbl_ram");

        // Busy duration for an ordinary write and for clear
        wr(0, 8'h00);
        tick(BusyCyc - 1);
        chk("busy_last", 32'(bus.busy), 32'd1);
        tick();
        chk("busy_end", 32'(bus.busy), 32'd0);
        wr(0, 8'h01);
        e = model_write(1'b0, 8'h01);
        tick(ClearCyc - 1);
        chk("clear_last", 32'(bus.busy), 32'd1);
        tick();
        chk("clear_end", 32'(bus.busy), 32'd0);

        // Writes with ON=0 or RW=1 are ignored
        wr(0, 8'h85, 1'b0, 1'b0);
        chk("off_strobe", 32'({wr_strobe, bus.busy}), 32'd0);
        wr(0, 8'h85, 1'b1, 1'b1);
        chk("rw_strobe", 32'({wr_strobe, bus.busy}), 32'd0);
        chk("ignored_ac", 32'(ac), 32'd0);

        // Overrun: second strobe during busy is dropped
        wr(0, 8'h85); e = model_write(1'b0, 8'h85); wait_idle();
        wr(1, 8'h33); e = model_write(1'b1, 8'h33);
        tick(10);
        wr(1, 8'h77);
        chk("ovr_pulse", 32'(overrun), 32'd1);
        chk("ovr_no_strobe", 32'(wr_strobe), 32'd0);
        wait_idle();
        chk("ovr_ac", 32'(ac), 32'h06);
        rd(5, v); chk("ovr_ram5", 32'(v), 32'h33);
        rd(6, v); chk("ovr_ram6", 32'(v), 32'h20);

        // Reset in the middle of a clear fill
        wr(0, 8'h01);
        tick(30);
        rst_n = 1'b0;
        tick();
        chk("midrst_flags", 32'({disp_on, cursor_on, blink_on, incr, two_line}), 32'b00010);
        chk("midrst_ac_busy", 32'({ac, bus.busy}), 32'd1);
        rst_n = 1'b1;
        model_reset();
        fill_check("midrst");

        // Randomized writes against the model
        for (int k = 0; k < 150; k++) begin
            rs = ($urandom_range(0, 2) != 0);
            d  = 8'($urandom);
            wr(rs, d);
            chk("rnd_strobe", 32'(wr_strobe), 32'd1);
            tick();
            e = model_write(rs, d);
            chk("rnd_addr_err", 32'(addr_err), 32'(e));
            if ($urandom_range(0, 7) == 0) begin
                sav_ac = m_ac;
                tick(3);
                wr(1'($urandom_range(0, 1)), 8'($urandom));
                chk("rnd_overrun", 32'({overrun, wr_strobe}), 32'b10);
                m_ac = sav_ac;
            end
            wait_idle();
            chk("rnd_ac", 32'(ac), 32'(m_ac));
            chk("rnd_flags", 32'({disp_on, cursor_on, blink_on, incr, two_line}),
                32'({m_disp, m_cur, m_blink, m_incr, m_two}));
        end
        cmp_ram("rnd_ram");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
